// File: rtl/bh1750_pkg.sv
// Shared constants, state encoding and read-data helper for the BH1750
// ambient-light-sensor I2C target model.
package bh1750_pkg;

    localparam logic [6:0] BH_DEF_ADDR  = 7'h23;

    localparam logic [7:0] OP_PWR_DOWN  = 8'h00;
    localparam logic [7:0] OP_PWR_ON    = 8'h01;
    localparam logic [7:0] OP_RESET     = 8'h07;
    localparam logic [7:0] OP_CONT_H    = 8'h10;
    localparam logic [7:0] OP_CONT_H2   = 8'h11;
    localparam logic [7:0] OP_CONT_L    = 8'h13;
    localparam logic [7:0] OP_ONCE_H    = 8'h20;
    localparam logic [7:0] OP_ONCE_H2   = 8'h21;
    localparam logic [7:0] OP_ONCE_L    = 8'h23;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_e;

    function automatic logic is_meas_op(input logic [7:0] op);
        return (op == OP_CONT_H) || (op == OP_CONT_H2) || (op == OP_CONT_L) ||
               (op == OP_ONCE_H) || (op == OP_ONCE_H2) || (op == OP_ONCE_L);
    endfunction

    // Reads beyond the two measurement bytes return all-ones padding.
    function automatic logic [7:0] rd_data(input logic [15:0] shadow, input logic [1:0] idx);
        case (idx)
            2'd0:    return shadow[15:8];
            2'd1:    return shadow[7:0];
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes and deglitches SCL/SDA, then derives SCL edge and
// START/STOP condition pulses from the filtered levels.
module i2c_bus_sync #(
    parameter int GLITCH_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    localparam int CNT_W = $clog2(GLITCH_CYC + 1);

    // Bit 1 carries SCL, bit 0 carries SDA.
    logic [1:0]       meta_q, sync_q, filt_q, prev_q;
    logic [CNT_W-1:0] cnt_q [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            filt_q <= 2'b11;
            prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            meta_q <= {scl_i, sda_i};
            sync_q <= meta_q;
            prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(GLITCH_CYC - 1)) begin
                    filt_q[i] <= sync_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sda_o      = filt_q[0];
    assign scl_rise_o = filt_q[1] & ~prev_q[1];
    assign scl_fall_o = ~filt_q[1] & prev_q[1];
    assign start_o    = prev_q[0] & ~filt_q[0] & filt_q[1] & prev_q[1];
    assign stop_o     = ~prev_q[0] & filt_q[0] & filt_q[1] & prev_q[1];

endmodule

// File: rtl/bh1750_i2c_target.sv
// BH1750-style I2C target: accepts command bytes, tracks power/mode state
// and returns a snapshot of lux_value on reads.
module bh1750_i2c_target
    import bh1750_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = BH_DEF_ADDR,
    parameter int         GLITCH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] lux_value,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        pwr_on,
    output logic [7:0]  meas_mode,
    output logic        busy
);

    logic sda_f, scl_rise, scl_fall, start_c, stop_c;

    i2c_bus_sync #(.GLITCH_CYC(GLITCH_CYC)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_c),
        .stop_o     (stop_c)
    );

    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [1:0]  byte_idx_q;
    logic [6:0]  shreg_q;
    logic [6:0]  tx_q;
    logic        rw_q, ack_ph_q;
    logic [15:0] shadow_q;
    logic        sda_oe_q, cmd_valid_q, pwr_on_q, busy_q;
    logic [7:0]  cmd_byte_q, meas_mode_q;

    logic [7:0]  rx_byte, nxt_tx;
    assign rx_byte = {shreg_q, sda_f};
    assign nxt_tx  = rd_data(shadow_q, byte_idx_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            shreg_q     <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            ack_ph_q    <= 1'b0;
            shadow_q    <= '0;
            sda_oe_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            pwr_on_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_byte_q  <= '0;
            meas_mode_q <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (stop_c) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                ack_ph_q <= 1'b0;
            end else if (start_c) begin
                state_q    <= ADDR;
                bit_cnt_q  <= '0;
                byte_idx_q <= '0;
                sda_oe_q   <= 1'b0;
                ack_ph_q   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        shreg_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == I2C_ADDR) begin
                                state_q <= ADDR_ACK;
                                rw_q    <= rx_byte[0];
                                busy_q  <= 1'b1;
                                if (rx_byte[0]) shadow_q <= lux_value;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    // First SCL fall drives the ACK, second fall ends the ACK slot.
                    ADDR_ACK, WR_ACK: if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_oe_q <= 1'b1;
                            ack_ph_q <= 1'b1;
                        end else begin
                            ack_ph_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_q    <= RD_BYTE;
                                tx_q       <= nxt_tx[6:0];
                                sda_oe_q   <= ~nxt_tx[7];
                                byte_idx_q <= 2'd1;
                            end else begin
                                state_q  <= WR_BYTE;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shreg_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q     <= WR_ACK;
                            cmd_byte_q  <= rx_byte;
                            cmd_valid_q <= 1'b1;
                            if (rx_byte == OP_PWR_DOWN) begin
                                pwr_on_q <= 1'b0;
                            end else if (rx_byte == OP_PWR_ON) begin
                                pwr_on_q <= 1'b1;
                            end else if (rx_byte == OP_RESET) begin
                                if (pwr_on_q) meas_mode_q <= 8'h00;
                            end else if (is_meas_op(rx_byte)) begin
                                meas_mode_q <= rx_byte;
                                pwr_on_q    <= 1'b1;
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= RD_ACK;
                        end else if (scl_fall) begin
                            sda_oe_q <= ~tx_q[6];
                            tx_q     <= {tx_q[5:0], 1'b1};
                        end
                    end
                    // Release on the fall after bit 7, sample the controller ACK on the rise.
                    RD_ACK: begin
                        if (scl_fall) begin
                            if (ack_ph_q) begin
                                state_q    <= RD_BYTE;
                                ack_ph_q   <= 1'b0;
                                bit_cnt_q  <= '0;
                                tx_q       <= nxt_tx[6:0];
                                sda_oe_q   <= ~nxt_tx[7];
                                byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd2 : byte_idx_q + 2'd1;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end else if (scl_rise) begin
                            if (sda_f) state_q  <= IGNORE;
                            else       ack_ph_q <= 1'b1;
                        end
                    end
                    IGNORE:  sda_oe_q <= 1'b0;
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign cmd_byte  = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;
    assign pwr_on    = pwr_on_q;
    assign meas_mode = meas_mode_q;
    assign busy      = busy_q;

endmodule

// File: doc/bh1750_i2c_target.md
BH1750_I2C_TARGET -- requirements
Module: bh1750_i2c_target

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h23, 7-bit target address to respond to.
REQ-002 SHALL have parameter GLITCH_CYC, default 2, the number of consecutive equal samples required before a synchronized SCL/SDA level is accepted.
REQ-003 SHALL have port clk, input, 1, system clock; reset rst_n, synchronous, active-low; clock clk.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port scl_i, input, 1, bus SCL (asynchronous).
REQ-006 SHALL have port sda_i, input, 1, bus SDA (asynchronous).
REQ-007 SHALL have port sda_oe, output, 1, meaning 1 = pull SDA low and 0 = release; the pad is open-drain external to this block.
REQ-008 SHALL have port lux_value, input, 16, the measurement presented on reads.
REQ-009 SHALL have port cmd_byte, output, 8, the last written command byte.
REQ-010 SHALL have port cmd_valid, output, 1, a one-cycle pulse when cmd_byte updates.
REQ-011 SHALL have port pwr_on, output, 1, emulated power state.
REQ-012 SHALL have port meas_mode, output, 8, the last accepted measurement opcode.
REQ-013 SHALL have port busy, output, 1, asserted from an addressed START until STOP.

Function
REQ-014 SHALL sample scl_i/sda_i through a 2-FF synchronizer plus the GLITCH_CYC filter; all edges derive from the filtered levels.
REQ-015 SHALL detect START as SDA falling while SCL=1, and STOP as SDA rising while SCL=1.
REQ-016 SHALL use FSM states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-017 SHALL sample SDA on SCL rising, MSB first, with the bit counter 0..7.
REQ-018 SHALL change sda_oe exactly 1 clk after a detected SCL falling edge, never while SCL=1 except on state exit via STOP.
REQ-019 SHALL go from IDLE to ADDR on START.
REQ-020 In ADDR, after 8 bits: on address match go to ADDR_ACK (drive ACK low for one SCL low/high period); on mismatch go to IGNORE with sda_oe=0.
REQ-021 On leaving ADDR_ACK, SHALL go to RD_BYTE if R/W=1, else to WR_BYTE.
REQ-022 SHALL snapshot lux_value into a 16-bit shadow register on the clock at which address match with R/W=1 is decided; the shadow is not updated again during the transfer.
REQ-023 RD_BYTE SHALL send byte 0 = shadow[15:8], byte 1 = shadow[7:0], and bytes 2+ = 8'hFF.
REQ-024 RD_BYTE SHALL release SDA for 1 bits and pull low for 0 bits.
REQ-025 RD_ACK SHALL release SDA and sample the controller ACK: on ACK (0) go to RD_BYTE with the next byte; on NACK (1) go to IGNORE.
REQ-026 WR_BYTE to WR_ACK SHALL always ACK, update cmd_byte, and pulse cmd_valid on the clock the 8th bit is sampled.
REQ-027 Command decode on each written byte: 0x00 sets pwr_on=0; 0x01 sets pwr_on=1; 0x07 clears meas_mode to 0x00 if pwr_on=1, otherwise it is ignored.
REQ-028 Command decode: 0x10, 0x11, 0x13, 0x20, 0x21, 0x23 set meas_mode and set pwr_on=1; other opcodes update cmd_byte only.
REQ-029 A STOP in any state SHALL go to IDLE with sda_oe=0 and busy=0.
REQ-030 A START in any state (repeated start) SHALL go to ADDR with the bit counter and byte index cleared.
REQ-031 Simultaneous STOP and SCL edge: STOP SHALL take priority.
REQ-032 IGNORE SHALL hold sda_oe=0 until START or STOP.

Reset
REQ-033 On rst_n=0, SHALL set state=IDLE, sda_oe=0, cmd_byte=0, cmd_valid=0, pwr_on=0, meas_mode=0, busy=0, shadow=0, and preset synchronizers to 1.
REQ-034 Reset mid-transfer SHALL release SDA on the next clk and ignore the bus until a fresh START.

Structure
REQ-035 SHALL place constants for the opcodes (0x00/0x01/0x07/0x10..0x23), the state enum and the default address in package bh1750_pkg.
REQ-036 SHALL use one sub-module, i2c_bus_sync: synchronizer, glitch filter, and scl_rise/scl_fall/start/stop pulses.
REQ-037 Intended clk is 25 MHz; the block SHALL operate correctly for SCL <= clk/16.

Verification
REQ-038 Write 0x46 then 0x01 -> ACK on both bytes, cmd_valid one pulse, cmd_byte=0x01, pwr_on=1.
REQ-039 Write 0x46 then 0x10 -> meas_mode=0x10; then lux_value=0xA55A, read 0x47 with controller ACK then NACK -> bytes 0xA5, 0x5A.
REQ-040 lux_value changes to 0x1234 during a read -> returned bytes remain 0xA5, 0x5A; a third ACKed byte returns 0xFF.
REQ-041 Address 0x50 write -> SDA never driven, busy=0, no cmd_valid; the following 0x46 transfer is ACKed.
REQ-042 Repeated START after writing 0x10, then 0x47 read -> ADDR re-entered and read data correct; STOP -> busy=0.
REQ-043 rst_n low during RD_BYTE with a 0 bit driven -> sda_oe=0 the next clk; all outputs at reset values.
